// File: rtl/logic_unit_serial.sv
// logic_unit_serial: multi-cycle AND/OR/XOR/NOR unit processing CHUNK bits per cycle, LSB slice first
//   clk, reset            : rising-edge clock, synchronous active-high reset
//   start, op, inpA, inpB : request and operands, sampled when ready=1
//   ready, done, result   : handshake, one-cycle completion pulse, registered result
//   zero                  : result==0 flag, present only with LOGIC_UNIT_ZERO_FLAG_EN
module logic_unit_serial #(
    parameter int WIDTH = 32,
    parameter int CHUNK = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] inpA,
    input  logic [WIDTH-1:0] inpB,
    output logic             ready,
    output logic             done,
`ifdef LOGIC_UNIT_ZERO_FLAG_EN
    output logic             zero,
`endif
    output logic [WIDTH-1:0] result
);
    localparam int N  = WIDTH / CHUNK;
    localparam int CW = N > 1 ? $clog2(N) : 1;
    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
    state_t state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [1:0] op_q, op_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d, wres_q, wres_d, result_q, result_d;
    logic done_q, done_d;
    logic [CHUNK-1:0] sa, sb, slice_res;
    logic accept, last;
`ifdef LOGIC_UNIT_ZERO_FLAG_EN
    logic zero_q, zero_d;
`endif
    assign accept = start && state_q != BUSY;
    assign last   = state_q == BUSY && cnt_q == CW'(N - 1);
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            op_q     <= '0;
            a_q      <= '0;
            b_q      <= '0;
            wres_q   <= '0;
            result_q <= '0;
            done_q   <= 1'b0;
`ifdef LOGIC_UNIT_ZERO_FLAG_EN
            zero_q   <= 1'b1;
`endif
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            op_q     <= op_d;
            a_q      <= a_d;
            b_q      <= b_d;
            wres_q   <= wres_d;
            result_q <= result_d;
            done_q   <= done_d;
`ifdef LOGIC_UNIT_ZERO_FLAG_EN
            zero_q   <= zero_d;
`endif
        end
    end
    always_comb begin
        state_d = state_q;
        if (state_q == BUSY)
            state_d = last ? DONE : BUSY;
        else
            state_d = start ? BUSY : IDLE;
    end
    always_comb begin
        sa = a_q[cnt_q*CHUNK +: CHUNK];
        sb = b_q[cnt_q*CHUNK +: CHUNK];
        slice_res = op_q == 2'd0 ? sa & sb :
                    op_q == 2'd1 ? sa | sb :
                    op_q == 2'd2 ? sa ^ sb : ~(sa | sb);
        op_d     = accept ? op : op_q;
        a_d      = accept ? inpA : a_q;
        b_d      = accept ? inpB : b_q;
        cnt_d    = accept ? '0 : (state_q == BUSY && !last) ? cnt_q + CW'(1) : cnt_q;
        wres_d   = wres_q;
        if (state_q == BUSY)
            wres_d[cnt_q*CHUNK +: CHUNK] = slice_res;
        // the final slice is merged combinationally so result never shows a partial word
        result_d = last ? wres_d : result_q;
        done_d   = last;
`ifdef LOGIC_UNIT_ZERO_FLAG_EN
        zero_d   = last ? (wres_d == '0) : zero_q;
`endif
    end
    always_comb begin
        ready  = state_q != BUSY;
        done   = done_q;
        result = result_q;
`ifdef LOGIC_UNIT_ZERO_FLAG_EN
        zero   = zero_q;
`endif
    end
endmodule
